muldiv_sequencer: RTL and testbench
===================================

# muldiv_sequencer

Execute-stage controller that shares the multi-cycle multiplier and divider units between the in-order instruction stream and single-cycle ALU results. It classifies each accepted instruction by `ctl.op`, starts the matching unit, and stalls the pipeline until that unit completes. It holds the result until the downstream stage accepts it, and cancels in-flight work on flush. Division by zero is resolved locally without starting the divider.

## Interface
- `DIV_FASTPATH`, default 1: when 1, a division with a zero divisor completes locally and `div_start` is never pulsed.
- `clk` in 1: clock, all state on rising edge.
- `reset` in 1: asynchronous, active-high.
- `in_valid` in 1: the issue stage presents an instruction.
- `in_ready` out 1: the instruction is accepted this cycle when `in_valid & in_ready`.
- `ctl` in `control_t`: decoded control; only `ctl.op` is used.
- `a`, `b` in `word_t`: operands, forwarded unregistered to the units.
- `c_alu` in `word_t`: single-cycle ALU result for the current instruction.
- `out_valid` out 1: `c` is valid.
- `out_ready` in 1: the downstream stage accepts `c`.
- `c` out `word_t`: selected result.
- `flush` in 1: synchronous pipeline kill.
- `mul_start` out 1: one-cycle pulse; the multiplier samples `ctl`, `a`, `b` in the same cycle.
- `mul_done` in 1: one-cycle pulse, qualifies `mul_c`.
- `mul_c` in `word_t`: multiplier result, already formatted for MUL/MULW.
- `div_start`, `div_done`, `div_c`: same protocol as the multiplier signals, for the DIV/DIVU/DIVW/DIVUW/REM/REMU/REMW/REMUW group.
- `kill` out 1: one-cycle pulse aborting whichever unit is busy.

## Operation
- Op classes:
  - MUL: MUL, MULW.
  - DIV: the eight divide and remainder ops.
  - ALU: every other op.
- States: IDLE, MUL_BUSY, DIV_BUSY, DONE.
- IDLE behaviour:
  - For an ALU op, `in_ready = out_ready`, `out_valid = in_valid`, `c = c_alu`. This path is combinational pass-through with no state change.
  - For a MUL or DIV op, `in_ready = 1`.
- On accepting a MUL op: assert `mul_start` and go to MUL_BUSY.
- On accepting a DIV op:
  - With a nonzero divisor: assert `div_start` and go to DIV_BUSY.
  - With a zero divisor and `DIV_FASTPATH = 1`: load `res_q` with the fast-path value and go to DONE.
- MUL_BUSY / DIV_BUSY: `in_ready = 0`, `out_valid = 0`. On the matching `*_done`, load `res_q` from `*_c` and go to DONE. A non-matching `done` is ignored.
- DONE: `out_valid = 1`, `c = res_q`, `in_ready = 0`. When `out_ready` is high, return to IDLE.
- Zero-divisor test: `b == 0` for 64-bit ops; `b[31:0] == 0` for W ops.
- Fast-path values:
  - DIV, DIVU: all ones.
  - DIVW, DIVUW: all ones (sign-extended -1).
  - REM, REMU: `a`.
  - REMW, REMUW: `{{32{a[31]}}, a[31:0]}`.
- Flush:
  - Takes effect from any state; the next state is IDLE.
  - `kill` is pulsed if the current state is MUL_BUSY or DIV_BUSY.
  - `flush` during an IDLE accept cycle suppresses `mul_start`, `div_start` and the fast-path load.
  - In DONE, `res_q` is discarded.
  - A `*_done` arriving in the same cycle as `flush` is ignored.
- A `*_done` arriving in IDLE or DONE is ignored. A stray pulse never produces `out_valid`.

## Timing
- Reset values:
  - State: IDLE.
  - `res_q`: 0.
  - `mul_start`, `div_start`, `kill`: 0.
  - `out_valid`: 0 unless the IDLE ALU pass-through is active.
- ALU op latency: 0 cycles.
- Unit op latency: accepted in cycle N, `*_done` arrives in cycle M ≥ N+1, `out_valid` is asserted in cycle M+1.
- Fast-path latency: accepted in cycle N, `out_valid` is asserted in cycle N+1.
- Throughput: at most one unit or fast-path op per two cycles; the DONE→IDLE transition costs one cycle.
- `mul_start`, `div_start` and `kill` are combinational from state and inputs; each is high for exactly one cycle per event.
- Reset asserted mid-operation forces IDLE immediately. No `kill` is issued; the units share the same reset.

## Structure
- The `pipes` package gains:
  - `mdseq_state_t`, a 2-bit enum for the four states.
  - Functions `is_mul_op(op)`, `is_div_op(op)`, `is_rem_op(op)` and `is_word_op(op)`.
- One sub-module, `div_fastpath`, which is combinational. It takes `op`, `a` and `b`, and outputs `zero_div` and `fast_c`.

## Test plan
- ADD with `c_alu = 5`, `out_ready = 1` → `out_valid = 1` and `c = 5` in the same cycle; state remains IDLE.
- MUL accepted; `mul_done` pulses 3 cycles later with `mul_c = 0x2A`; `out_ready = 0` for 2 cycles, then 1 → `c = 0x2A` held across the stall and `in_ready = 0` throughout; IDLE one cycle after the handshake.
- DIVU with `b = 0` → no `div_start`; the next cycle shows `out_valid = 1`, `c = 0xFFFFFFFFFFFFFFFF`. REMW with `a = 0x1_8000_0000`, `b = 0x1_0000_0000` → `c = 0xFFFFFFFF80000000`.
- DIV in DIV_BUSY with `flush` asserted → `kill` pulses once; state goes to IDLE; a later `div_done` is ignored and `out_valid` stays 0.
- `flush` in the same cycle a MUL is accepted → no `mul_start` and no state change. `flush` coincident with `mul_done` → no output.
- `reset` asserted asynchronously in DONE → `out_valid` drops at once without waiting for a clock edge; after release, a REM with `b = 3`, `a = 10` and `div_c = 1` produces `c = 1`.

Source files
------------

// File: rtl/muldiv_sequencer_pkg.sv
// Shared pipeline types for the execute stage plus op-class helpers used by the
// multiply/divide sequencer.
package pipes;

  typedef logic [63:0] word_t;

  typedef enum logic [4:0] {
    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SLL, OP_SRL, OP_SRA,
    OP_SLT, OP_SLTU, OP_ADDW, OP_SUBW,
    OP_MUL, OP_MULW,
    OP_DIV, OP_DIVU, OP_DIVW, OP_DIVUW,
    OP_REM, OP_REMU, OP_REMW, OP_REMUW
  } op_t;

  typedef struct packed {
    op_t op;
  } control_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MUL_BUSY,
    ST_DIV_BUSY,
    ST_DONE
  } mdseq_state_t;

  function automatic logic is_mul_op(op_t op);
    return op inside {OP_MUL, OP_MULW};
  endfunction

  function automatic logic is_div_op(op_t op);
    return op inside {OP_DIV, OP_DIVU, OP_DIVW, OP_DIVUW,
                      OP_REM, OP_REMU, OP_REMW, OP_REMUW};
  endfunction

  function automatic logic is_rem_op(op_t op);
    return op inside {OP_REM, OP_REMU, OP_REMW, OP_REMUW};
  endfunction

  function automatic logic is_word_op(op_t op);
    return op inside {OP_ADDW, OP_SUBW, OP_MULW, OP_DIVW, OP_DIVUW,
                      OP_REMW, OP_REMUW};
  endfunction

endpackage

// File: rtl/muldiv_sequencer_div_fastpath.sv
// Combinational divide-by-zero detector; produces the architectural result so
// the divider never has to be started for a zero divisor.
module div_fastpath
  import pipes::*;
(
  input  op_t   op,
  input  word_t a,
  input  word_t b,
  output logic  zero_div,
  output word_t fast_c
);

  logic word_op;

  assign word_op  = is_word_op(op);
  assign zero_div = word_op ? (b[31:0] == 32'd0) : (b == 64'd0);

  // Quotient of x/0 is -1; remainder of x/0 is the dividend (sign-extended for W).
  always_comb begin
    fast_c = '1;
    if (is_rem_op(op)) begin
      fast_c = word_op ? {{32{a[31]}}, a[31:0]} : a;
    end
  end

endmodule

// File: rtl/muldiv_sequencer.sv
// Execute-stage controller: passes ALU results straight through and sequences
// the shared multi-cycle multiplier and divider, holding their result until taken.
module muldiv_sequencer
  import pipes::*;
#(
  parameter bit DIV_FASTPATH = 1'b1
)(
  input  logic     clk,
  input  logic     reset,
  input  logic     in_valid,
  output logic     in_ready,
  input  control_t ctl,
  input  word_t    a,
  input  word_t    b,
  input  word_t    c_alu,
  output logic     out_valid,
  input  logic     out_ready,
  output word_t    c,
  input  logic     flush,
  output logic     mul_start,
  input  logic     mul_done,
  input  word_t    mul_c,
  output logic     div_start,
  input  logic     div_done,
  input  word_t    div_c,
  output logic     kill
);

  mdseq_state_t state_q, state_d;
  word_t        res_q, res_d;
  logic         zero_div;
  word_t        fast_c;
  logic         op_mul, op_div;

  div_fastpath u_fastpath (
    .op       (ctl.op),
    .a        (a),
    .b        (b),
    .zero_div (zero_div),
    .fast_c   (fast_c)
  );

  assign op_mul = is_mul_op(ctl.op);
  assign op_div = is_div_op(ctl.op);

  always_comb begin
    state_d   = state_q;
    res_d     = res_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    c         = res_q;
    mul_start = 1'b0;
    div_start = 1'b0;
    kill      = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (op_mul || op_div) begin
          in_ready = 1'b1;
          // A flush in the accept cycle drops the instruction entirely.
          if (in_valid && !flush) begin
            if (op_mul) begin
              mul_start = 1'b1;
              state_d   = ST_MUL_BUSY;
            end else if (DIV_FASTPATH && zero_div) begin
              res_d   = fast_c;
              state_d = ST_DONE;
            end else begin
              div_start = 1'b1;
              state_d   = ST_DIV_BUSY;
            end
          end
        end else begin
          in_ready  = out_ready;
          out_valid = in_valid;
          c         = c_alu;
        end
      end
      ST_MUL_BUSY: begin
        if (flush) begin
          kill    = 1'b1;
          state_d = ST_IDLE;
        end else if (mul_done) begin
          res_d   = mul_c;
          state_d = ST_DONE;
        end
      end
      ST_DIV_BUSY: begin
        if (flush) begin
          kill    = 1'b1;
          state_d = ST_IDLE;
        end else if (div_done) begin
          res_d   = div_c;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        out_valid = 1'b1;
        if (flush || out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      res_q   <= res_d;
    end
  end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Bench for muldiv_sequencer: table of ops driven through a scoreboard, plus
// directed flush, stray-done and asynchronous-reset sequences.
module tb_muldiv_sequencer;
  import pipes::*;

  logic     clk = 1'b0;
  logic     reset;
  logic     in_valid, in_ready;
  control_t ctl;
  word_t    a, b, c_alu, c, mul_c, div_c;
  logic     out_valid, out_ready, flush;
  logic     mul_start, mul_done, div_start, div_done, kill;

  int total = 0;
  int bad   = 0;
  word_t sb[$];

  always #5 clk = ~clk;

  muldiv_sequencer #(.DIV_FASTPATH(1'b1)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .ctl       (ctl),
    .a         (a),
    .b         (b),
    .c_alu     (c_alu),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .c         (c),
    .flush     (flush),
    .mul_start (mul_start),
    .mul_done  (mul_done),
    .mul_c     (mul_c),
    .div_start (div_start),
    .div_done  (div_done),
    .div_c     (div_c),
    .kill      (kill)
  );

  // kind: 0 = ALU pass-through, 1 = multiplier, 2 = divider, 3 = zero-divisor fast path
  typedef struct {
    op_t   op;
    word_t a;
    word_t b;
    word_t c_alu;
    word_t unit_c;
    word_t exp_c;
    int    kind;
    int    dly;
    int    stall;
  } vec_t;

  task automatic chk(input string name, input word_t act, input word_t exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Output monitor: every valid result must match the oldest expected entry.
  always @(negedge clk) begin
    if (out_valid === 1'b1) begin
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL spurious_out: got out_valid=1 c=%h expected no output", c);
      end else if (c !== sb[0]) begin
        bad++;
        $display("FAIL result: got %h expected %h", c, sb[0]);
        if (out_ready) void'(sb.pop_front());
      end else if (out_ready) begin
        void'(sb.pop_front());
      end
    end
  end

  task automatic run_op(input vec_t v);
    ctl.op   = v.op;
    a        = v.a;
    b        = v.b;
    c_alu    = v.c_alu;
    in_valid = 1'b1;
    if (v.kind == 0) begin
      out_ready = 1'b1;
      sb.push_back(v.exp_c);
      #1;
      chk("alu_in_ready", word_t'(in_ready), 64'd1);
      chk("alu_out_valid", word_t'(out_valid), 64'd1);
      step();
      in_valid  = 1'b0;
      out_ready = 1'b0;
      return;
    end
    out_ready = 1'b0;
    sb.push_back(v.exp_c);
    #1;
    chk("accept_in_ready", word_t'(in_ready), 64'd1);
    chk("mul_start", word_t'(mul_start), word_t'(v.kind == 1));
    chk("div_start", word_t'(div_start), word_t'(v.kind == 2));
    step();
    in_valid = 1'b0;
    chk("start_pulse_off", word_t'(mul_start | div_start), 64'd0);
    chk("busy_in_ready", word_t'(in_ready), 64'd0);
    if (v.kind != 3) begin
      for (int i = 0; i < v.dly - 1; i++) begin
        mul_done = (i == 0) && (v.kind == 2);
        div_done = (i == 0) && (v.kind == 1);
        mul_c    = 64'hBAD0_BAD0_BAD0_BAD0;
        div_c    = 64'hBAD1_BAD1_BAD1_BAD1;
        #1;
        chk("busy_out_valid", word_t'(out_valid), 64'd0);
        step();
      end
      mul_done = (v.kind == 1);
      div_done = (v.kind == 2);
      mul_c    = v.unit_c;
      div_c    = v.unit_c;
      #1;
      chk("done_cycle_out_valid", word_t'(out_valid), 64'd0);
      step();
      mul_done = 1'b0;
      div_done = 1'b0;
    end
    chk("result_latency", word_t'(out_valid), 64'd1);
    for (int i = 0; i < v.stall; i++) begin
      chk("stall_in_ready", word_t'(in_ready), 64'd0);
      step();
    end
    out_ready = 1'b1;
    #1;
    chk("done_in_ready", word_t'(in_ready), 64'd0);
    step();
    out_ready = 1'b0;
    ctl.op    = OP_MUL;
    #1;
    chk("back_idle_in_ready", word_t'(in_ready), 64'd1);
    chk("back_idle_out_valid", word_t'(out_valid), 64'd0);
  endtask

  vec_t vecs[10];

  initial begin
    vecs[0] = '{OP_ADD,   64'd1, 64'd2, 64'd5,   64'd0, 64'd5, 0, 0, 0};
    vecs[1] = '{OP_SUBW,  64'd9, 64'd3, 64'hFFFF_FFFF_FFFF_FFF0, 64'd0,
                64'hFFFF_FFFF_FFFF_FFF0, 0, 0, 0};
    vecs[2] = '{OP_MUL,   64'd6, 64'd7, 64'd0, 64'h2A, 64'h2A, 1, 3, 2};
    vecs[3] = '{OP_MULW,  64'd3, 64'd3, 64'd0, 64'hFFFF_FFFF_8000_0000,
                64'hFFFF_FFFF_8000_0000, 1, 1, 0};
    vecs[4] = '{OP_DIVU,  64'd77, 64'd0, 64'd0, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 3, 0, 1};
    vecs[5] = '{OP_REMW,  64'h1_8000_0000, 64'h1_0000_0000, 64'd0, 64'd0,
                64'hFFFF_FFFF_8000_0000, 3, 0, 0};
    vecs[6] = '{OP_DIVW,  64'd5, 64'hFFFF_FFFF_0000_0000, 64'd0, 64'd0,
                64'hFFFF_FFFF_FFFF_FFFF, 3, 0, 0};
    vecs[7] = '{OP_REMU,  64'h1234, 64'd0, 64'd0, 64'd0, 64'h1234, 3, 0, 0};
    vecs[8] = '{OP_REMUW, 64'hDEAD_BEEF_8000_0001, 64'd0, 64'd0, 64'd0,
                64'hFFFF_FFFF_8000_0001, 3, 0, 0};
    vecs[9] = '{OP_DIV,   64'd99, 64'h1_0000_0000, 64'd0, 64'h55, 64'h55, 2, 4, 1};

    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
    ctl.op = OP_MUL; a = '0; b = '0; c_alu = '0;
    mul_done = 1'b0; div_done = 1'b0; mul_c = '0; div_c = '0;
    #2;
    chk("rst_out_valid", word_t'(out_valid), 64'd0);
    chk("rst_pulses", word_t'({mul_start, div_start, kill}), 64'd0);
    step();
    reset = 1'b0;
    #1;
    chk("rst_res_q", c, 64'd0);
    chk("rst_idle_in_ready", word_t'(in_ready), 64'd1);

    for (int i = 0; i < 10; i++) begin
      step();
      run_op(vecs[i]);
    end

    // Flush while the divider is busy.
    step();
    ctl.op = OP_DIV; a = 64'd100; b = 64'd7; in_valid = 1'b1;
    #1;
    chk("fl_div_start", word_t'(div_start), 64'd1);
    step();
    in_valid = 1'b0; flush = 1'b1;
    #1;
    chk("fl_kill", word_t'(kill), 64'd1);
    step();
    flush = 1'b0;
    #1;
    chk("fl_kill_once", word_t'(kill), 64'd0);
    chk("fl_idle", word_t'(in_ready), 64'd1);
    div_done = 1'b1; div_c = 64'd9;
    step();
    div_done = 1'b0;
    chk("fl_late_done", word_t'(out_valid), 64'd0);
    step();
    chk("fl_late_done2", word_t'(out_valid), 64'd0);

    // Flush in the accept cycle of a MUL.
    ctl.op = OP_MUL; in_valid = 1'b1; flush = 1'b1;
    #1;
    chk("fa_no_mul_start", word_t'(mul_start), 64'd0);
    step();
    in_valid = 1'b0; flush = 1'b0;
    #1;
    chk("fa_still_idle", word_t'(in_ready), 64'd1);

    // Flush coincident with mul_done.
    step();
    in_valid = 1'b1;
    #1;
    chk("fd_mul_start", word_t'(mul_start), 64'd1);
    step();
    in_valid = 1'b0; mul_done = 1'b1; mul_c = 64'd77; flush = 1'b1;
    #1;
    chk("fd_kill", word_t'(kill), 64'd1);
    step();
    mul_done = 1'b0; flush = 1'b0;
    #1;
    chk("fd_no_out", word_t'(out_valid), 64'd0);
    chk("fd_idle", word_t'(in_ready), 64'd1);

    // Stray done pulses in IDLE.
    mul_done = 1'b1; div_done = 1'b1;
    step();
    mul_done = 1'b0; div_done = 1'b0;
    chk("stray_done", word_t'(out_valid), 64'd0);

    // Asynchronous reset while holding a result in DONE.
    step();
    ctl.op = OP_DIVU; a = '0; b = '0; in_valid = 1'b1; out_ready = 1'b0;
    sb.push_back(64'hFFFF_FFFF_FFFF_FFFF);
    step();
    in_valid = 1'b0;
    chk("ar_done_valid", word_t'(out_valid), 64'd1);
    #1;
    reset = 1'b1;
    #1;
    chk("ar_async_drop", word_t'(out_valid), 64'd0);
    sb.delete();
    step();
    reset = 1'b0;
    step();
    run_op('{OP_REM, 64'd10, 64'd3, 64'd0, 64'd1, 64'd1, 2, 2, 0});

    step();
    chk("sb_drained", word_t'(sb.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
